// File: rtl/ula_pkg.sv
// ula_pkg: shared opcodes, FSM state encoding and the combinational ALU function
// used by ula_multiciclo and the ULA control stage.
package ula_pkg;

    localparam logic [3:0] ULA_ADD  = 4'b0001;
    localparam logic [3:0] ULA_SUB  = 4'b0010;
    localparam logic [3:0] ULA_SLL  = 4'b0011;
    localparam logic [3:0] ULA_SLT  = 4'b0100;
    localparam logic [3:0] ULA_SLTU = 4'b0101;
    localparam logic [3:0] ULA_SRL  = 4'b0110;
    localparam logic [3:0] ULA_SRA  = 4'b0111;
    localparam logic [3:0] ULA_XOR  = 4'b1000;
    localparam logic [3:0] ULA_OR   = 4'b1001;
    localparam logic [3:0] ULA_AND  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == ULA_SLL) || (sel == ULA_SRL) || (sel == ULA_SRA);
    endfunction

    // Illegal opcodes fall through to zero.
    function automatic logic [31:0] ula_compute(input logic [3:0] sel, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (sel)
            ULA_ADD:  ula_compute = a + b;
            ULA_SUB:  ula_compute = a - b;
            ULA_SLL:  ula_compute = a << sh;
            ULA_SLT:  ula_compute = {31'd0, $signed(a) < $signed(b)};
            ULA_SLTU: ula_compute = {31'd0, a < b};
            ULA_SRL:  ula_compute = a >> sh;
            ULA_SRA:  ula_compute = $unsigned($signed(a) >>> sh);
            ULA_XOR:  ula_compute = a ^ b;
            ULA_OR:   ula_compute = a | b;
            ULA_AND:  ula_compute = a & b;
            default:  ula_compute = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/ula_shifter_serial.sv
// ula_shifter_serial: one-bit-per-step shift datapath with down-counter; o_next is
// the value after the current step, o_last flags the final step.
module ula_shifter_serial
    import ula_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_next,
    output logic        o_last
);

    logic [31:0] r_value;
    logic [4:0]  r_cnt;
    logic        r_left;
    logic        r_arith;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_load) begin
            r_value <= i_data;
            r_cnt   <= i_shamt;
            r_left  <= i_sel == ULA_SLL;
            r_arith <= i_sel == ULA_SRA;
        end else if (i_step) begin
            r_value <= o_next;
            r_cnt   <= r_cnt - 5'd1;
        end
    end

    assign o_next = r_left ? {r_value[30:0], 1'b0} : {r_arith & r_value[31], r_value[31:1]};
    assign o_last = r_cnt == 5'd1;

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multicycle ALU, latency 2 (serial shifts 2+shamt).
// Define ULA_FAST_SHIFT_EN to use a barrel shifter so every op takes 2 cycles.
module ula_multiciclo
    import ula_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  ula_select,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_sel;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_done;
    logic [31:0] r_result;
    logic [31:0] w_alu;
    logic        w_serial;
    logic [31:0] w_shift_next;
    logic        w_last;
    logic        w_fin;

    assign w_alu = ula_compute(r_sel, r_a, r_b);

`ifdef ULA_FAST_SHIFT_EN
    assign w_serial     = 1'b0;
    assign w_shift_next = '0;
    assign w_last       = 1'b0;
`else
    // Shifts by zero complete through the plain ALU path.
    assign w_serial = is_shift(r_sel) && (r_b[4:0] != 5'd0);

    ula_shifter_serial u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (r_state == EXEC && w_serial),
        .i_step  (r_state == SHIFT),
        .i_sel   (r_sel),
        .i_data  (r_a),
        .i_shamt (r_b[4:0]),
        .o_next  (w_shift_next),
        .o_last  (w_last)
    );
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? EXEC : IDLE;
            EXEC:    w_next = w_serial ? SHIFT : IDLE;
            SHIFT:   w_next = w_last ? IDLE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    assign w_fin = (r_state == EXEC && !w_serial) || (r_state == SHIFT && w_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_done   <= 1'b0;
            r_result <= '0;
            r_sel    <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fin;
            if (w_fin)
                r_result <= (r_state == SHIFT) ? w_shift_next : w_alu;
            if (r_state == IDLE && start) begin
                r_sel <= ula_select;
                r_a   <= op_a;
                r_b   <= op_b;
            end
        end
    end

    assign busy   = r_state != IDLE;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_result == 32'd0;

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed self-checking bench for ula_multiciclo.
module tb_ula_multiciclo;
    import ula_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ula_select = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    int          checks = 0;
    int          failures = 0;

`ifdef ULA_FAST_SHIFT_EN
    localparam int SRA31_LAT = 2;
    localparam int SRL4_LAT  = 2;
    localparam int SLL8_LAT  = 2;
`else
    localparam int SRA31_LAT = 33;
    localparam int SRL4_LAT  = 6;
    localparam int SLL8_LAT  = 10;
`endif

    ula_multiciclo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ula_select (ula_select),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    // Issues one op, scrambles inputs after acceptance, waits for done.
    // lat counts edges from the accepting edge up to the one that raises done.
    task automatic run_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        start = 1'b1; ula_select = s; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; ula_select = ULA_AND; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
        lat = 1;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; ula_select = ULA_ADD; op_a = 32'd1; op_b = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL rst_result got=%h exp=0", result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL rst_zero got=%b exp=1", zero); end
        rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_discard busy got=%b exp=0", busy); end
    endtask

    task automatic test_arith();
        int lat;
        run_op(ULA_SUB, 32'd10, 32'd3, lat);
        checks++; if (result !== 32'd7) begin failures++; $display("FAIL sub got=%h exp=%h", result, 32'd7); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL sub_zero got=%b exp=0", zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sub_busy_on_done got=%b exp=0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
        checks++; if (result !== 32'd7) begin failures++; $display("FAIL result_hold got=%h exp=%h", result, 32'd7); end
        start = 1'b1; ula_select = ULA_ADD; op_a = 32'hFFFF_FFFF; op_b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0; op_a = 32'd0; op_b = 32'd0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_early_done got=%b exp=0", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL add_latency done got=%b exp=1", done); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL add_wrap got=%h exp=0", result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL add_zero got=%b exp=1", zero); end
    endtask

    task automatic test_compare();
        int lat;
        run_op(ULA_SLT, 32'hFFFF_FFFE, 32'd1, lat);
        checks++; if (result !== 32'd1) begin failures++; $display("FAIL slt got=%h exp=1", result); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL slt_lat got=%0d exp=2", lat); end
        run_op(ULA_SLTU, 32'hFFFF_FFFE, 32'd1, lat);
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL sltu got=%h exp=0", result); end
    endtask

    task automatic test_logic_shift();
        int lat;
        run_op(ULA_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, lat);
        checks++; if (result !== 32'h5A5A_A5A5) begin failures++; $display("FAIL xor got=%h exp=5a5aa5a5", result); end
        run_op(ULA_OR, 32'h0000_00F0, 32'h0000_0F0F, lat);
        checks++; if (result !== 32'h0000_0FFF) begin failures++; $display("FAIL or got=%h exp=00000fff", result); end
        run_op(ULA_AND, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
        checks++; if (result !== 32'h00F0_1200) begin failures++; $display("FAIL and got=%h exp=00f01200", result); end
        run_op(ULA_SRL, 32'hF000_000F, 32'd4, lat);
        checks++; if (result !== 32'h0F00_0000) begin failures++; $display("FAIL srl got=%h exp=0f000000", result); end
        checks++; if (lat !== SRL4_LAT) begin failures++; $display("FAIL srl_lat got=%0d exp=%0d", lat, SRL4_LAT); end
        run_op(ULA_SLL, 32'h1234_5678, 32'h0000_0020, lat);
        checks++; if (result !== 32'h1234_5678) begin failures++; $display("FAIL sll0 got=%h exp=12345678", result); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL sll0_lat got=%0d exp=2", lat); end
    endtask

    task automatic test_sra();
        int lat;
        run_op(ULA_SRA, 32'h8000_0000, 32'd31, lat);
        checks++; if (result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sra got=%h exp=ffffffff", result); end
        checks++; if (lat !== SRA31_LAT) begin failures++; $display("FAIL sra_lat got=%0d exp=%0d", lat, SRA31_LAT); end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        int first = 0;
        logic [31:0] res = '0;
        start = 1'b1; ula_select = ULA_SLL; op_a = 32'h0000_00A5; op_b = 32'd8;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
        ula_select = ULA_ADD; op_a = 32'd1; op_b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 2; i <= 20; i++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = i;
                res = result;
            end
            @(posedge clk); #1;
        end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
        checks++; if (first !== SLL8_LAT) begin failures++; $display("FAIL ign_lat got=%0d exp=%0d", first, SLL8_LAT); end
        checks++; if (res !== 32'h0000_A500) begin failures++; $display("FAIL ign_result got=%h exp=0000a500", res); end
    endtask

    task automatic test_reset_mid_shift();
        int ndone = 0;
        start = 1'b1; ula_select = ULA_SRA; op_a = 32'h8000_0000; op_b = 32'd20;
        @(posedge clk); #1;
        start = 1'b0;
`ifndef ULA_FAST_SHIFT_EN
        repeat (4) @(posedge clk);
        #1;
`endif
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_inflight busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", done); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL mid_rst_result got=%h exp=0", result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL mid_rst_zero got=%b exp=1", zero); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL mid_rst_late_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_illegal_back_to_back();
        int lat;
        run_op(ULA_OR, 32'd5, 32'd3, lat);
        checks++; if (result !== 32'd7) begin failures++; $display("FAIL pre_illegal got=%h exp=7", result); end
        run_op(4'b0000, 32'd5, 32'd3, lat);
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL illegal0 got=%h exp=0", result); end
        run_op(ULA_OR, 32'd5, 32'd3, lat);
        run_op(4'b1111, 32'd5, 32'd3, lat);
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL illegal15 got=%h exp=0", result); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL illegal_lat got=%0d exp=2", lat); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_on_done got=%b exp=1", done); end
        run_op(ULA_ADD, 32'd2, 32'd3, lat);
        checks++; if (result !== 32'd5) begin failures++; $display("FAIL b2b_add got=%h exp=5", result); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_lat got=%0d exp=2", lat); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_logic_shift();
        test_sra();
        test_busy_ignore();
        test_reset_mid_shift();
        test_illegal_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
